// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between an instruction
// fetch port (I) and a load/store port (D). Arbitration is round-robin; each
// granted transaction runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_req/i_addr               instruction read request, held until i_valid
//   i_rdata/i_valid            fetched word, one-cycle completion pulse
//   d_req/d_wen/d_addr/d_wdata data request (wen=1 store), held until d_valid
//   d_rdata/d_valid            load data, one-cycle completion pulse
//   m_en/m_wen/m_addr/m_wdata  RAM access strobe, write enable, address, data
//   m_rdata                    RAM read data, valid MEM_LAT cycles after m_en
//   grant                      current owner: 00 none, 01 I, 10 D
module mem_arbiter #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic [WORD_LEN-1:0] i_rdata,
  output logic                i_valid,
  input  logic                d_req,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_valid,
  output logic                m_en,
  output logic                m_wen,
  output logic [WORD_LEN-1:0] m_addr,
  output logic [WORD_LEN-1:0] m_wdata,
  input  logic [WORD_LEN-1:0] m_rdata,
  output logic [1:0]          grant
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_d;
  logic             owner;     // 0 = I, 1 = D
  logic             last_d;    // last served requester was D
  logic             wen_q;     // latched write flag of current transaction
  logic [CNT_W-1:0] cnt;
  logic             start;     // grant decision taken this cycle
  logic             pick_d;    // winner of the grant decision

  // Next-state and round-robin grant decision.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    pick_d  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          start   = 1'b1;
          state_d = ISSUE;
          // On conflict, serve whoever was not served last.
          pick_d  = (i_req && d_req) ? ~last_d : d_req;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last_d  <= 1'b0;
      wen_q   <= 1'b0;
      cnt     <= '0;
      m_en    <= 1'b0;
      m_wen   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      grant   <= 2'b00;
    end else begin
      state   <= state_d;
      // Strobes are derived from the next state so they line up with it.
      m_en    <= start;
      m_wen   <= start & pick_d & d_wen;
      i_valid <= (state_d == DONE) && !owner;
      d_valid <= (state_d == DONE) && owner;

      if (start) begin
        owner   <= pick_d;
        wen_q   <= pick_d & d_wen;
        m_addr  <= pick_d ? d_addr : i_addr;
        m_wdata <= d_wdata;
        grant   <= {pick_d, ~pick_d};
      end else if (state_d == IDLE) begin
        grant   <= 2'b00;
      end

      if (state == ISSUE) begin
        last_d <= owner;
        cnt    <= LAT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt    <= cnt - CNT_W'(1);
      end

      // Read data is valid during the last WAIT cycle.
      if (state == WAIT && cnt == '0 && !wen_q) begin
        if (owner) d_rdata <= m_rdata;
        else       i_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a main instance (MEM_LAT=2) backed by a
// RAM model, plus MEM_LAT=1 and MEM_LAT=15 instances whose read data is the
// cycle number, so captured data reveals the capture cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_valid, d_valid, m_en, m_wen;
  logic [1:0]  grant;

  logic        f_req1, f_req15;
  logic [31:0] x_rdata;
  logic [31:0] r1, r15, dr1, dr15, ma1, ma15, mw1, mw15;
  logic        v1, v15, dv1, dv15, men1, men15, mwe1, mwe15;
  logic [1:0]  g1, g15;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) x_rdata <= 32'(cyc);

  mem_arbiter #(.WORD_LEN(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .grant(grant));

  mem_arbiter #(.WORD_LEN(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(f_req1), .i_addr(32'h0), .i_rdata(r1), .i_valid(v1),
    .d_req(1'b0), .d_wen(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(dr1), .d_valid(dv1),
    .m_en(men1), .m_wen(mwe1), .m_addr(ma1), .m_wdata(mw1),
    .m_rdata(x_rdata), .grant(g1));

  mem_arbiter #(.WORD_LEN(32), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .i_req(f_req15), .i_addr(32'h0), .i_rdata(r15), .i_valid(v15),
    .d_req(1'b0), .d_wen(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(dr15), .d_valid(dv15),
    .m_en(men15), .m_wen(mwe15), .m_addr(ma15), .m_wdata(mw15),
    .m_rdata(x_rdata), .grant(g15));

  // RAM model with 2-cycle read latency; non-access cycles emit a sentinel.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe0, rd_pipe1;
  always @(posedge clk) begin
    if (m_en && m_wen) mem[m_addr[9:2]] <= m_wdata;
    rd_pipe0 <= m_en ? mem[m_addr[9:2]] : 32'hBAD0BAD0;
    rd_pipe1 <= rd_pipe0;
  end
  assign m_rdata = rd_pipe1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = I, 1 = D
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t q1[$];
  exp_t q15[$];

  task automatic push(input logic port, input logic [31:0] data, input int c);
    exp_t e;
    e.port = port; e.data = data; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (i_valid || d_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {30'h0, d_valid, i_valid}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("valid_port", {30'h0, d_valid, i_valid}, e.port ? 32'h2 : 32'h1);
        chk("rdata", e.port ? d_rdata : i_rdata, e.data);
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (v1) begin
      if (q1.size() == 0) chk("l1_unexpected_valid", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        chk("l1_rdata", r1, e.data);
        chk("l1_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (v15) begin
      if (q15.size() == 0) chk("l15_unexpected_valid", 32'h1, 32'h0);
      else begin
        e = q15.pop_front();
        chk("l15_rdata", r15, e.data);
        chk("l15_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Per-run trace of the main instance.
  logic [1:0]  glog [0:63];
  int          men_cnt, men_first, wen_bad;
  logic [31:0] men_addr;
  logic        men_wen;

  // Drive requests from cycle 0 (current negedge); hold each req until it has
  // completed ni / nd times, then drop it in the cycle after its last valid.
  task automatic run(input int ni, input int nd, input logic wen,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
    int ri, rd, k;
    ri = ni; rd = nd; k = 0;
    i_req = (ni > 0); i_addr = ia;
    d_req = (nd > 0); d_wen = wen; d_addr = da; d_wdata = wd;
    men_cnt = 0; men_first = -1; wen_bad = 0; men_addr = 32'h0; men_wen = 1'b0;
    forever begin
      glog[k] = grant;
      if (m_en) begin
        if (men_cnt == 0) begin men_first = k; men_addr = m_addr; men_wen = m_wen; end
        men_cnt++;
      end else if (m_wen) wen_bad++;
      if (i_valid && ri > 0) begin ri--; if (ri == 0) i_req = 1'b0; end
      if (d_valid && rd > 0) begin rd--; if (rd == 0) d_req = 1'b0; end
      if (ri == 0 && rd == 0) break;
      if (k >= 60) begin
        chk("run_timeout", 32'(ri + rd), 32'h0);
        i_req = 1'b0; d_req = 1'b0;
        break;
      end
      k++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c0, n1, n15, k;
    exp_t e;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'hCAFEF00D;
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_wen = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    f_req1 = 0; f_req15 = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_outs", {27'h0, m_en, m_wen, i_valid, d_valid, 1'b0}, 32'h0);
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch
    push(1'b0, 32'h00000013, cyc + 4);
    run(1, 0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("fetch_men_cnt", 32'(men_cnt), 32'd1);
    chk("fetch_men_cycle", 32'(men_first), 32'd1);
    chk("fetch_m_addr", men_addr, 32'h0);
    chk("fetch_m_wen", {31'h0, men_wen}, 32'h0);
    chk("fetch_grant_c0", {30'h0, glog[0]}, 32'h0);
    for (int i = 1; i <= 4; i++) chk("fetch_grant", {30'h0, glog[i]}, 32'h1);

    // Store then load
    push(1'b1, 32'h0, cyc + 4);
    run(0, 1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF);
    chk("store_men_cycle", 32'(men_first), 32'd1);
    chk("store_m_wen", {31'h0, men_wen}, 32'h1);
    chk("store_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("store_wen_no_en", 32'(wen_bad), 32'h0);
    chk("store_grant", {30'h0, glog[2]}, 32'h2);
    push(1'b1, 32'hDEADBEEF, cyc + 4);
    run(0, 1, 1'b0, 32'h0, 32'h100, 32'h0);

    // Conflict after reset: D first, then I
    pulse_reset();
    push(1'b1, 32'hDEADBEEF, cyc + 4);
    push(1'b0, 32'h00100093, cyc + 9);
    run(1, 1, 1'b0, 32'h4, 32'h100, 32'h0);
    chk("conf_men_cnt", 32'(men_cnt), 32'd2);
    chk("conf_grant_c4", {30'h0, glog[4]}, 32'h2);
    chk("conf_grant_c5", {30'h0, glog[5]}, 32'h0);
    chk("conf_grant_c6", {30'h0, glog[6]}, 32'h1);

    // Sustained conflict: D, I, D, I
    push(1'b1, 32'hCAFEF00D, cyc + 4);
    push(1'b0, 32'h00100093, cyc + 9);
    push(1'b1, 32'hCAFEF00D, cyc + 14);
    push(1'b0, 32'h00100093, cyc + 19);
    run(2, 2, 1'b0, 32'h4, 32'h8, 32'h0);
    chk("rr_men_cnt", 32'(men_cnt), 32'd4);

    // Latency extremes
    c0 = cyc;
    e.port = 1'b0; e.data = 32'(c0 + 2);  e.cyc = c0 + 3;  q1.push_back(e);
    e.port = 1'b0; e.data = 32'(c0 + 16); e.cyc = c0 + 17; q15.push_back(e);
    f_req1 = 1'b1; f_req15 = 1'b1;
    n1 = 0; n15 = 0; k = 0;
    while ((f_req1 || f_req15) && k < 40) begin
      if (men1) n1++;
      if (men15) n15++;
      if (v1) f_req1 = 1'b0;
      if (v15) f_req15 = 1'b0;
      k++;
      @(negedge clk);
    end
    if (f_req1 || f_req15) chk("lat_timeout", {30'h0, f_req15, f_req1}, 32'h0);
    f_req1 = 1'b0; f_req15 = 1'b0;
    @(negedge clk);
    chk("l1_men_cnt", 32'(n1), 32'd1);
    chk("l15_men_cnt", 32'(n15), 32'd1);

    // Reset during WAIT of a load: abandoned, no d_valid
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h8;
    @(negedge clk);
    chk("abort_issue_men", {31'h0, m_en}, 32'h1);
    @(negedge clk);
    chk("abort_wait_grant", {30'h0, grant}, 32'h2);
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("abort_outs", {28'h0, m_en, m_wen, i_valid, d_valid}, 32'h0);
    chk("abort_grant", {30'h0, grant}, 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    chk("abort_m_addr", m_addr, 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    push(1'b1, 32'hCAFEF00D, cyc + 4);
    push(1'b0, 32'h00000013, cyc + 9);
    run(1, 1, 1'b0, 32'h0, 32'h8, 32'h0);

    repeat (4) @(negedge clk);
    chk("sb_leftover", 32'(sbq.size() + q1.size() + q15.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port.
- Arbitrates requests round-robin, then sequences one memory access per transaction.
- Each access is issue, a fixed read-latency wait, then a one-cycle response pulse to the winning requester.
- Sits between core (ImemPort/DmemPort, adapted to req/valid) and a unified RAM.

Parameters:
- WORD_LEN, 32, data/address width.
- MEM_LAT, 2, memory read latency in cycles from the m_en edge to valid m_rdata; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  instruction read request; held until i_valid
- i_addr  in  WORD_LEN  instruction address
- i_rdata  out  WORD_LEN  fetched instruction
- i_valid  out  1  one-cycle completion pulse for I
- d_req  in  1  data request; held until d_valid
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  WORD_LEN  data address
- d_wdata  in  WORD_LEN  store data
- d_rdata  out  WORD_LEN  load data
- d_valid  out  1  one-cycle completion pulse for D (loads and stores)
- m_en  out  1  memory access strobe
- m_wen  out  1  memory write enable
- m_addr  out  WORD_LEN  memory address
- m_wdata  out  WORD_LEN  memory write data
- m_rdata  in  WORD_LEN  memory read data
- grant  out  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- Single clock. Reset is synchronous and active-low: rst_n is sampled on the rising clk edge only.
- Reset values:
  - state IDLE, last_grant = I.
  - All outputs 0: m_en, m_wen, m_addr, m_wdata, i_valid, d_valid, i_rdata, d_rdata, grant.
- FSM:
  - IDLE:
    - No req: stay in IDLE.
    - Only one req: grant it.
    - Both reqs: grant the requester not equal to last_grant.
    - On grant, latch owner, addr, wen (forced 0 for I) and wdata, then go to ISSUE.
  - ISSUE (1 cycle):
    - m_en=1, m_wen=latched wen, m_addr/m_wdata = latched values; last_grant <= owner.
    - Go to WAIT.
  - WAIT (exactly MEM_LAT cycles):
    - A 4-bit down-counter loaded with MEM_LAT-1 in ISSUE; exit when the counter is 0.
    - m_rdata is registered into the owner's rdata register at the end of the last WAIT cycle, for reads only.
  - DONE (1 cycle):
    - Owner's valid=1 and rdata stable; return to IDLE.
- Latency: request first seen in IDLE at cycle 0 gives valid in cycle MEM_LAT+2. Throughput is one access per MEM_LAT+3 cycles.
- m_en is high only in ISSUE. m_wen is 0 whenever m_en=0. m_addr/m_wdata hold the last latched values.
- grant equals the owner in ISSUE/WAIT/DONE and is 00 in IDLE.
- Stores: d_valid pulses in DONE with identical timing; d_rdata keeps its previous value.
- Requester protocol:
  - req, addr, wen and wdata are sampled only in IDLE; later changes are ignored until the next grant.
  - A requester wanting no further access must have req low in the cycle after valid. req still high in IDLE starts a new transaction.
- The losing requester keeps req high and is served next (round-robin guarantees no starvation).
- A new req arriving during ISSUE/WAIT/DONE waits until IDLE; nothing is queued.
- i_rdata/d_rdata change only on their own read completion.
- Reset mid-transaction: FSM goes to IDLE and the transaction is abandoned with no valid pulse. A store whose ISSUE edge has already passed is committed; no partial write is possible.
- Address is passed through unaligned; no checking or byte enables.

Test Plan:
- Single fetch, MEM_LAT=2, RAM[0x0]=0x00000013, i_req=1 addr 0x0 at cycle 0 -> m_en=1 in cycle 1 only with m_addr 0x0; i_valid=1 only in cycle 4 with i_rdata 0x00000013; grant 01 in cycles 1-4.
- Store then load: d_req, d_wen=1, addr 0x100, wdata 0xDEADBEEF -> m_wen=1 in cycle 1, d_valid in cycle 4, d_rdata unchanged. Then a load from 0x100 -> d_rdata 0xDEADBEEF.
- Conflict after reset: i_req and d_req both high in cycle 0 -> D served first (d_valid cycle 4); I granted in the following IDLE (cycle 5); m_en cycle 6; i_valid cycle 9.
- Sustained conflict for 4 transactions -> grant order D, I, D, I; no requester is granted twice in a row.
- MEM_LAT=1 and MEM_LAT=15 -> valid exactly at cycle 3 and cycle 17; m_en asserted exactly once per transaction.
- rst_n=0 during WAIT of a load -> next edge: outputs 0, state IDLE, no d_valid. Re-issuing the load after reset completes normally with last_grant reset to I.
